// File: rtl/line_priority_encoder_if.sv
// rtl/line_priority_encoder_if.sv - line bus and code handshake bundle for line_priority_encoder
interface line_priority_encoder_if;
  logic [3:0] d;
  logic [1:0] code;
  logic       valid;
  logic       ready;
  logic       err;
  logic       busy;

  modport master (
    output d,
    output ready,
    input  code,
    input  valid,
    input  err,
    input  busy
  );

  modport slave (
    input  d,
    input  ready,
    output code,
    output valid,
    output err,
    output busy
  );
endinterface

// File: rtl/line_priority_encoder.sv
// rtl/line_priority_encoder.sv - synchronise, debounce and encode a one-hot line bus into a handshaked 2-bit code
module line_priority_encoder #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  line_priority_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, HOLD} state_t;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);

  logic [3:0]       sync1, s, s_prev;
  logic [CNT_W-1:0] cnt;
  logic             settled, one_hot;
  logic [1:0]       enc;
  state_t           state, state_n;
  logic             load_code, err_n;
  logic [1:0]       code_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      s      <= '0;
      s_prev <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= bus.d;
      s      <= sync1;
      s_prev <= s;
      if (s != s_prev)
        cnt <= '0;
      else if (cnt != DB_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // The s == s_prev term stops a change that lands on the saturation cycle from being taken as settled.
  assign settled = (cnt == DB_MAX) && (s == s_prev);
  assign one_hot = $onehot(s);

  always_comb begin
    enc = 2'b00;
    case (s)
      4'b0010: enc = 2'b01;
      4'b0100: enc = 2'b10;
      4'b1000: enc = 2'b11;
      default: enc = 2'b00;
    endcase
  end

  always_comb begin
    state_n   = state;
    load_code = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (s != 4'b0000)
          state_n = SETTLE;
      end
      SETTLE: begin
        if (s == 4'b0000) begin
          state_n = IDLE;
        end else if (settled) begin
          if (one_hot) begin
            load_code = 1'b1;
            state_n   = EMIT;
          end else begin
            err_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
      EMIT: begin
        if (bus.ready)
          state_n = HOLD;
      end
      HOLD: begin
        if (settled && (s == 4'b0000))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      code_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (load_code)
        code_q <= enc;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = (state == EMIT);
  assign bus.err   = err_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_line_priority_encoder.sv
// tb/tb_line_priority_encoder.sv - scoreboard bench for line_priority_encoder with DB_CYCLES=4 and DB_CYCLES=1 instances
module tb_line_priority_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  line_priority_encoder_if ifa();
  line_priority_encoder_if ifb();

  line_priority_encoder #(.DB_CYCLES(4), .CNT_W(8)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  line_priority_encoder #(.DB_CYCLES(1), .CNT_W(8)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int checks = 0;
  int failures = 0;
  // Entries 0..3 are expected codes, 4 is an expected err pulse.
  int exp_a[$];
  int exp_b[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      check("a_err_valid_excl", int'(ifa.valid & ifa.err), 0);
      if (ifa.valid && ifa.ready) begin
        if (exp_a.size() == 0) check("a_unexpected_code", int'(ifa.code), -1);
        else check("a_code", int'(ifa.code), exp_a.pop_front());
      end
      if (ifa.err) begin
        if (exp_a.size() == 0) check("a_unexpected_err", 4, -1);
        else check("a_err", 4, exp_a.pop_front());
      end
      if (ifb.valid && ifb.ready) begin
        if (exp_b.size() == 0) check("b_unexpected_code", int'(ifb.code), -1);
        else check("b_code", int'(ifb.code), exp_b.pop_front());
      end
      if (ifb.err) begin
        if (exp_b.size() == 0) check("b_unexpected_err", 4, -1);
        else check("b_err", 4, exp_b.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after driving d at a negedge; the next posedge is edge 0.
  task automatic wait_valid(input bit on_b, input int bound, output int k);
    k = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (on_b ? ifb.valid : ifa.valid) return;
    end
    k = -99;
  endtask

  task automatic wait_err(input int bound, output int k);
    k = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (ifa.err) return;
    end
    k = -99;
  endtask

  initial begin
    int k;
    int bad;
    ifa.d = 4'b0000; ifa.ready = 1'b0;
    ifb.d = 4'b0000; ifb.ready = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_code", int'(ifa.code), 0);
    check("rst_valid", int'(ifa.valid), 0);
    check("rst_err", int'(ifa.err), 0);
    check("rst_busy", int'(ifa.busy), 0);
    rst_n = 1'b1;
    idle(3);

    // Basic one-hot press with ready already high.
    ifa.ready = 1'b1;
    ifa.d = 4'b0100;
    exp_a.push_back(2);
    wait_valid(1'b0, 30, k);
    check("t1_latency", k, 7);
    @(negedge clk);
    check("t1_valid_one_cycle", int'(ifa.valid), 0);
    check("t1_busy_hold", int'(ifa.busy), 1);
    ifa.d = 4'b0000;
    idle(12);
    check("t1_back_idle", int'(ifa.busy), 0);

    // Back-pressure: valid and code held while ready is low.
    ifa.ready = 1'b0;
    ifa.d = 4'b1000;
    exp_a.push_back(3);
    wait_valid(1'b0, 30, k);
    check("t2_latency", k, 7);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.valid !== 1'b1 || ifa.code !== 2'b11) bad++;
    end
    check("t2_held_cycles_bad", bad, 0);
    ifa.ready = 1'b1;
    @(negedge clk);
    check("t2_drop_after_ready", int'(ifa.valid), 0);
    idle(20);
    check("t2_no_second_valid", int'(ifa.valid), 0);
    ifa.d = 4'b0000;
    idle(12);

    // Bounce then stable press.
    for (int i = 0; i < 6; i++) begin
      ifa.d = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      idle(2);
    end
    ifa.d = 4'b0001;
    exp_a.push_back(0);
    wait_valid(1'b0, 30, k);
    check("t3_latency", k, 7);
    ifa.d = 4'b0000;
    idle(12);

    // Multi-hot flags err, then a legal press still works.
    ifa.d = 4'b0110;
    exp_a.push_back(4);
    wait_err(30, k);
    check("t4_err_latency", k, 7);
    @(negedge clk);
    check("t4_err_one_cycle", int'(ifa.err), 0);
    idle(10);
    check("t4_no_valid", int'(ifa.valid), 0);
    ifa.d = 4'b0000;
    idle(12);
    check("t4_idle_after_release", int'(ifa.busy), 0);
    ifa.d = 4'b0010;
    exp_a.push_back(1);
    wait_valid(1'b0, 30, k);
    check("t4_latency", k, 7);
    ifa.d = 4'b0000;
    idle(12);

    // Asynchronous reset while a code is pending.
    ifa.ready = 1'b0;
    ifa.d = 4'b1000;
    wait_valid(1'b0, 30, k);
    check("t5_latency", k, 7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", int'(ifa.valid), 0);
    check("t5_rst_busy", int'(ifa.busy), 0);
    check("t5_rst_err", int'(ifa.err), 0);
    ifa.d = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    ifa.ready = 1'b1;
    idle(20);
    check("t5_no_code_after_rst", int'(ifa.busy), 0);

    // DB_CYCLES=1 instance: press, release, press.
    ifb.ready = 1'b1;
    ifb.d = 4'b0001;
    exp_b.push_back(0);
    wait_valid(1'b1, 30, k);
    check("t6_latency_first", k, 4);
    ifb.d = 4'b0000;
    idle(8);
    ifb.d = 4'b0001;
    exp_b.push_back(0);
    wait_valid(1'b1, 30, k);
    check("t6_latency_second", k, 4);
    ifb.d = 4'b0000;
    idle(8);

    check("queue_a_drained", exp_a.size(), 0);
    check("queue_b_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
